// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with Mealy match pulse,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0110,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b0,
    localparam int                LW          = $clog2(MAX_LEN+1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic               accept;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic               fill_ok;
    logic               match_int;

    always_comb begin
        accept    = in_valid & ~cfg_load;
        cand      = {hist_q[MAX_LEN-2:0], in};
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        fill_ok   = (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q});
        match_int = accept & ~cfg_err_q & fill_ok &
                    ((cand & len_mask) == (pat_q & len_mask));
    end

    // Config load wins over data; a non-overlapping match consumes its bits
    // by clearing fill, which masks whatever stale bits remain in hist.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load) begin
            pat_d     = cfg_pattern;
            len_d     = cfg_len;
            ovl_d     = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            count_d   = '0;
            cfg_err_d = (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
        end else if (accept) begin
            hist_d = {hist_q[MAX_LEN-2:0], in};
            if (match_int && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LW'(MAX_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
            if (match_int && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q     <= RST_PATTERN;
            len_q     <= LW'(RST_LEN);
            ovl_q     <= RST_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_int & rstn;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a bit-history reference model predicts
// each cycle's outputs for an 8-bit and a 2-bit counter instance.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    typedef struct {
        bit m;
        bit err;
        int c8;
        int c2;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               match_a, match_b;
    logic [7:0]         count_a;
    logic [1:0]         count_b;
    logic               err_a, err_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: bits accepted since the last clear
    bit       hist_bits[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_err;
    int       m_c8;
    int       m_c2;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in(in_bit), .match(match_a), .match_count(count_a), .cfg_err(err_a)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in(in_bit), .match(match_b), .match_count(count_b), .cfg_err(err_b)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        hist_bits.delete();
        m_pat = 8'b0000_0110;
        m_len = 4;
        m_ovl = 1'b0;
        m_err = 1'b0;
        m_c8  = 0;
        m_c2  = 0;
    endfunction

    // The newest len bits, oldest first, must equal pattern bits len-1 down to 0
    function automatic bit model_match(bit b);
        int n;
        bit x;
        if (m_err) return 1'b0;
        n = hist_bits.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            x = (k == m_len - 1) ? b : hist_bits[n - (m_len - 1) + k];
            if (x != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst_low, input bit load, input bit [7:0] pat,
                                 input int len, input bit ovl, input bit v, input bit b);
        exp_t e;
        @(negedge clk);
        rstn        = ~rst_low;
        cfg_load    = load;
        cfg_pattern = pat;
        cfg_len     = LW'(len);
        cfg_overlap = ovl;
        in_valid    = v;
        in_bit      = b;
        if (rst_low) begin
            model_reset();
            e = '{1'b0, 1'b0, 0, 0};
            exp_q.push_back(e);
        end else if (load) begin
            e = '{1'b0, m_err, m_c8, m_c2};
            exp_q.push_back(e);
            hist_bits.delete();
            m_pat = pat;
            m_len = len;
            m_ovl = ovl;
            m_err = (len == 0) || (len > MAX_LEN);
            m_c8  = 0;
            m_c2  = 0;
        end else if (v) begin
            e = '{model_match(b), m_err, m_c8, m_c2};
            exp_q.push_back(e);
            hist_bits.push_back(b);
            if (e.m) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
                if (!m_ovl) hist_bits.delete();
            end
            if (hist_bits.size() > MAX_LEN) void'(hist_bits.pop_front());
        end else begin
            e = '{1'b0, m_err, m_c8, m_c2};
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bits(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(0, 0, 8'h00, 0, 0, 1, bits[i]);
    endtask

    task automatic load_cfg(input bit [7:0] pat, input int len, input bit ovl);
        applyStimulus(0, 1, pat, len, ovl, 1, 1);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("match_a", int'(match_a), int'(e.m));
                checkOutput("match_b", int'(match_b), int'(e.m));
                checkOutput("count_a", int'(count_a), e.c8);
                checkOutput("count_b", int'(count_b), e.c2);
                checkOutput("cfg_err", int'(err_a), int'(e.err));
                checkOutput("cfg_err_b", int'(err_b), int'(e.err));
            end
        end
    end

    initial begin
        int r;
        int wait_cycles;
        model_reset();
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 1, 1);

        send_bits(16'b0110110, 7);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);

        load_cfg(8'b0110, 4, 1);
        send_bits(16'b0110110, 7);

        load_cfg(8'b1, 1, 0);
        send_bits(16'b11, 2);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        send_bits(16'b01, 2);
        send_bits(16'b11111, 5);

        load_cfg(8'b1, 0, 0);
        send_bits(16'b1011_0110_1111, 12);
        load_cfg(8'hFF, 8, 0);
        send_bits(16'hFFFF, 12);

        applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
        send_bits(16'b011, 3);
        applyStimulus(1, 0, 8'h00, 0, 0, 1, 0);
        send_bits(16'b0, 1);
        send_bits(16'b110, 3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                applyStimulus(0, 1, 8'($urandom),
                              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
                              1'($urandom), 1'($urandom), 1'($urandom));
            end else if (r == 3) begin
                applyStimulus(1, 0, 8'h00, 0, 0, 1'($urandom), 1'($urandom));
            end else begin
                applyStimulus(0, 0, 8'h00, 0, 0, $urandom_range(0, 3) != 0, 1'($urandom));
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 0110 detector. It compares a 1-bit input stream against a pattern of 1..MAX_LEN bits, selectable at runtime along with overlapping or non-overlapping mode. It produces a Mealy match pulse and a saturating match counter. It sits on serial control/monitor paths and resets to the legacy behaviour: 0110, non-overlapping.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be >= 2.
- CNT_W, 8: match counter width.
- RST_PATTERN, 8'b0000_0110: pattern value after reset (MAX_LEN bits).
- RST_LEN, 4: pattern length after reset.
- RST_OVERLAP, 1'b0: overlap mode after reset.
- LW: derived, $clog2(MAX_LEN+1).
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last; bits >= len ignored.
- cfg_len  in  LW  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  qualifies in.
- in  in  1  serial data bit.
- match  out  1  Mealy pulse, high in the cycle the final pattern bit is presented.
- match_count  out  CNT_W  number of matches since reset/cfg_load, saturating.
- cfg_err  out  1  active configuration is illegal (len 0 or > MAX_LEN); detection is disabled.

## Operation
- State:
  - pat, len, ovl: the configuration registers.
  - hist[MAX_LEN-1:0]: hist[0] holds the newest accepted bit.
  - fill: count of bits accepted since the last clear, saturating at MAX_LEN.
  - match_count and cfg_err.
- Reset values: pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP, hist=0, fill=0, match_count=0, cfg_err=0. match is 0 while rstn is low.
- Accept: in_valid=1 and cfg_load=0. When in_valid=0, all state holds and match=0.
- cand = {hist[len-2:0], in}, i.e. the last len bits including the current one. For len=1, cand = in.
- match = accept & !cfg_err & (fill+1 >= len) & (cand[len-1:0] == pat[len-1:0]).
- On an accept edge:
  - hist shifts left with in entering at bit 0.
  - If match & !ovl: fill <= 0. The matched bits are consumed, and hist may keep stale bits, masked by fill.
  - Otherwise fill <= min(fill+1, MAX_LEN).
- match_count increments on each match and saturates at 2^CNT_W-1, with no wrap.
- cfg_load (priority over in_valid):
  - pat/len/ovl load from the cfg inputs.
  - hist=0, fill=0, match_count=0.
  - cfg_err <= (cfg_len==0) | (cfg_len>MAX_LEN).
  - The in bit that cycle is discarded and match=0.
- cfg_err=1: no matches and match_count holds; hist/fill keep updating. It clears only on a legal cfg_load or reset.
- Width rule: comparisons use only the low len bits. Upper bits of cfg_pattern are don't-care and stored unchanged.
- Reset mid-sequence: all progress is discarded and detection restarts from fill=0 with the RST_* configuration.

## Timing
- match is combinational from in, in_valid, cfg_load and registered state: 0-cycle latency from the final bit.
- match_count reflects a match after the same rising edge, i.e. visible 1 cycle after the match pulse.
- New configuration takes effect for bits presented from the cycle after cfg_load; cfg_err is valid from that cycle too.
- Back-to-back accepts at full rate are supported; there is no throughput restriction.
- Minimum spacing between matches:
  - overlapping: 1 cycle, possible for self-overlapping patterns.
  - non-overlapping: len accepted bits.

## Test plan
- Reset defaults, accepted stream 0,1,1,0,1,1,0 -> match only on bit 4 (the 4th bit); match_count=1 after the stream.
- cfg_load pattern 0110, len 4, overlap=1, same stream -> match on bits 4 and 7; match_count=2.
- len=1, pattern 1, overlap=0, stream 1,1,0,1 with an in_valid=0 gap cycle after the 2nd bit -> match on bits 1, 2 and 4; no match in the gap cycle; match_count=3.
- CNT_W=2, len=1, pattern 1, five accepted 1s -> match pulses 5 times; match_count sequence 1,2,3,3,3.
- cfg_load with cfg_len=0 -> cfg_err=1 next cycle and no match for any stream. Then load len=MAX_LEN with an all-ones pattern -> cfg_err=0, and the first match occurs on exactly the MAX_LEN-th consecutive 1.
- Stream 0,1,1, then assert rstn low for 1 cycle, then 0 -> no match. A following 1,1,0 -> match on the final 0.
